// File: rtl/imem_boot_sequencer.sv
// Boot/run controller: loads a length-prefixed little-endian byte image into
// instruction memory, then releases the core until it halts on a jump-to-self.
module imem_boot_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int HALT_CYCLES = 4,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  input  logic [31:0]           cpu_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           run_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam logic [31:0] DEPTH        = 32'd1 << ADDR_WIDTH;
  localparam logic [31:0] HALT_LAST    = 32'(HALT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = (RUN_TIMEOUT == 0) ? 32'd0 : 32'(RUN_TIMEOUT - 1);

  state_t                state_r, state_nxt_s;
  logic                  rx_ready_r, imem_we_r, cpu_reset_r, busy_r, done_r, error_r;
  logic [ADDR_WIDTH-1:0] imem_waddr_r;
  logic [31:0]           imem_wdata_r, run_cycles_r;
  logic [7:0]            wc_lo_r;
  logic [15:0]           word_count_r, word_idx_r;
  logic [1:0]            byte_idx_r;
  logic [23:0]           wbuf_r;
  logic [31:0]           prev_pc_r, stable_cnt_r;

  logic                  accept_s, hdr_bad_s, load_more_s, halt_hit_s, timeout_hit_s;
  logic [15:0]           hdr_count_s;
  logic [31:0]           rc_inc_s, stable_nxt_s;

  // Handshake, header validation and run-phase monitors
  always_comb begin
    accept_s      = rx_valid && rx_ready_r;
    hdr_count_s   = {rx_data, wc_lo_r};
    hdr_bad_s     = (hdr_count_s == 16'd0) || ({16'd0, hdr_count_s} > DEPTH);
    load_more_s   = (word_idx_r < word_count_r);
    rc_inc_s      = (run_cycles_r == 32'hFFFF_FFFF) ? run_cycles_r : run_cycles_r + 32'd1;
    stable_nxt_s  = (cpu_pc == prev_pc_r) ? stable_cnt_r + 32'd1 : 32'd0;
    halt_hit_s    = (stable_nxt_s >= HALT_LAST);
    timeout_hit_s = (RUN_TIMEOUT != 0) && (rc_inc_s >= TIMEOUT_LAST);
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_HDR0;
        else       state_nxt_s = ST_IDLE;
      end
      ST_HDR0: begin
        if (accept_s) state_nxt_s = ST_HDR1;
        else          state_nxt_s = ST_HDR0;
      end
      ST_HDR1: begin
        if (accept_s) state_nxt_s = hdr_bad_s ? ST_ERROR : ST_LOAD;
        else          state_nxt_s = ST_HDR1;
      end
      ST_LOAD: begin
        // word_idx_r already points past the word being written this cycle
        if (imem_we_r && (word_idx_r == word_count_r)) state_nxt_s = ST_RUN;
        else                                           state_nxt_s = ST_LOAD;
      end
      ST_RUN: begin
        if (start)              state_nxt_s = ST_HDR0;
        else if (halt_hit_s)    state_nxt_s = ST_HALT;
        else if (timeout_hit_s) state_nxt_s = ST_ERROR;
        else                    state_nxt_s = ST_RUN;
      end
      ST_HALT, ST_ERROR: begin
        if (start) state_nxt_s = ST_HDR0;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      rx_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= 32'd0;
      cpu_reset_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      run_cycles_r <= 32'd0;
      wc_lo_r      <= 8'd0;
      word_count_r <= 16'd0;
      word_idx_r   <= 16'd0;
      byte_idx_r   <= 2'd0;
      wbuf_r       <= 24'd0;
      prev_pc_r    <= 32'hFFFF_FFFF;
      stable_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      rx_ready_r  <= (state_nxt_s == ST_HDR0) || (state_nxt_s == ST_HDR1) || (state_nxt_s == ST_LOAD);
      busy_r      <= (state_nxt_s == ST_HDR0) || (state_nxt_s == ST_HDR1) ||
                     (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_RUN);
      done_r      <= (state_nxt_s == ST_HALT);
      error_r     <= (state_nxt_s == ST_ERROR);
      cpu_reset_r <= (state_nxt_s != ST_RUN);
      imem_we_r   <= 1'b0;
      case (state_r)
        ST_HDR0: begin
          if (accept_s) wc_lo_r <= rx_data;
        end
        ST_HDR1: begin
          if (accept_s) begin
            word_count_r <= hdr_count_s;
            word_idx_r   <= 16'd0;
            byte_idx_r   <= 2'd0;
            imem_waddr_r <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_s && load_more_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0:    wbuf_r[7:0]   <= rx_data;
              2'd1:    wbuf_r[15:8]  <= rx_data;
              2'd2:    wbuf_r[23:16] <= rx_data;
              default: begin
                imem_we_r    <= 1'b1;
                imem_wdata_r <= {rx_data, wbuf_r};
                imem_waddr_r <= word_idx_r[ADDR_WIDTH-1:0];
                word_idx_r   <= word_idx_r + 16'd1;
              end
            endcase
          end
          if (state_nxt_s == ST_RUN) begin
            run_cycles_r <= 32'd0;
            stable_cnt_r <= 32'd0;
            prev_pc_r    <= 32'hFFFF_FFFF;
          end
        end
        ST_RUN: begin
          if (!start) begin
            run_cycles_r <= rc_inc_s;
            stable_cnt_r <= stable_nxt_s;
            prev_pc_r    <= cpu_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = rx_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_waddr = imem_waddr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign run_cycles = run_cycles_r;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer: write scoreboard plus halt, timeout,
// header-error, restart and asynchronous-reset scenarios.
module tb_imem_boot_sequencer;

  logic        clk, reset_n, start, rx_valid, rx_ready, imem_we, cpu_reset;
  logic        busy, done, error;
  logic [7:0]  rx_data, imem_waddr;
  logic [31:0] imem_wdata, cpu_pc, run_cycles;

  int checks = 0;
  int errors = 0;
  int wr_idx = 0;
  int we_dbl = 0;
  logic prev_we = 1'b0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];

  imem_boot_sequencer #(.ADDR_WIDTH(8), .HALT_CYCLES(4), .RUN_TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .cpu_pc(cpu_pc), .busy(busy), .done(done), .error(error),
    .run_cycles(run_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture every write strobe mid-cycle and flag back-to-back strobes
  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_waddr, imem_wdata});
    if (imem_we && prev_we) we_dbl = we_dbl + 1;
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rx_ready;
      tick();
    end
    chk("byte_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] data, input bit gap);
    exp_q.push_back({addr, data});
    for (int k = 0; k < 4; k++) begin
      send_byte(data[8*k +: 8]);
      if (gap) begin
        rx_valid = 1'b0;
        tick();
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 60 && cpu_reset; i++) tick();
    chk("run_entry_cpu_reset", 64'(cpu_reset), 64'd0);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 60 && !done && !error; i++) tick();
  endtask

  task automatic check_writes();
    chk("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = wr_idx; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk("wr_addr_data", 64'(got_q[i]), 64'(exp_q[i]));
    end
    wr_idx = exp_q.size();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; cpu_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 64'({rx_ready, imem_we, cpu_reset, busy, done, error}), 64'b001000);
    chk("rst_waddr_wdata", 64'({imem_waddr, imem_wdata}), 64'd0);
    chk("rst_run_cycles", 64'(run_cycles), 64'd0);
    reset_n = 1'b1;
    tick();

    // 3-word image back to back, then halt on PC 0,4,8,8,8,8
    pulse_start();
    chk("hdr0_busy_ready", 64'({busy, rx_ready, cpu_reset}), 64'b111);
    send_byte(8'h03); send_byte(8'h00);
    send_word(8'd0, 32'h0500_0820, 1'b0);
    send_word(8'd1, 32'h0700_0920, 1'b0);
    send_word(8'd2, 32'h0200_0008, 1'b0);
    wait_run();
    check_writes();
    tick(); cpu_pc = 32'd4;
    tick(); cpu_pc = 32'd8;
    wait_end();
    chk("halt_flags", 64'({done, error, busy, cpu_reset, rx_ready}), 64'b10010);
    chk("halt_run_cycles", 64'(run_cycles), 64'd6);
    tick();
    chk("halt_hold_cycles", 64'(run_cycles), 64'd6);

    // start in HALT restarts; zero-length header errors without writes
    pulse_start();
    chk("restart_flags", 64'({done, busy, rx_ready, cpu_reset}), 64'b0111);
    chk("restart_cycles_held", 64'(run_cycles), 64'd6);
    send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    chk("hdr_zero_err", 64'({error, busy, rx_ready, cpu_reset}), 64'b1001);
    chk("hdr_zero_no_write", 64'(got_q.size()), 64'(exp_q.size()));

    // 257 words exceeds a 256-word memory
    pulse_start();
    chk("restart_err_clear", 64'(error), 64'd0);
    send_byte(8'h01); send_byte(8'h01);
    rx_valid = 1'b0;
    chk("hdr_257_err", 64'(error), 64'd1);
    chk("hdr_257_no_write", 64'(got_q.size()), 64'(exp_q.size()));

    // Throttled load with a stray start mid-load, then run into the timeout
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    rx_valid = 1'b0;
    tick();
    send_word(8'd0, 32'h0500_0820, 1'b1);
    pulse_start();
    chk("start_in_load_ignored", 64'({busy, rx_ready, cpu_reset}), 64'b111);
    send_word(8'd1, 32'h0700_0920, 1'b1);
    send_word(8'd2, 32'h0200_0008, 1'b1);
    wait_run();
    check_writes();
    chk("no_double_we", 64'(we_dbl), 64'd0);
    cpu_pc = 32'd0;
    for (int i = 0; i < 30 && !error && !done; i++) begin
      cpu_pc = cpu_pc + 32'd4;
      tick();
    end
    chk("timeout_flags", 64'({error, done, cpu_reset, busy}), 64'b1010);
    chk("timeout_run_cycles", 64'(run_cycles), 64'd9);

    // Async reset after 6 load bytes discards the partial word
    pulse_start();
    chk("err_restart_cycles_held", 64'({error, run_cycles}), 64'd9);
    send_byte(8'h02); send_byte(8'h00);
    send_word(8'd0, 32'h1122_3344, 1'b0);
    send_byte(8'hAA); send_byte(8'hBB);
    rx_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_flags", 64'({rx_ready, imem_we, cpu_reset, busy, done, error}), 64'b001000);
    chk("async_rst_data", 64'({imem_waddr, imem_wdata, run_cycles}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(8'd0, 32'hDEAD_BEEF, 1'b0);
    wait_run();
    check_writes();
    cpu_pc = 32'h100;
    wait_end();
    chk("const_pc_halt", 64'({done, cpu_reset}), 64'b11);
    chk("const_pc_cycles", 64'(run_cycles), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
